// File: rtl/packet_snooper.sv
// rtl/packet_snooper.sv - passive AXI-Stream tap capturing packets into a ping/pong buffer (optional SNOOPER_DROP_COUNT_EN)
module packet_snooper #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [63:0]             snoop_TDATA,
    input  logic [7:0]              snoop_TKEEP,
    input  logic                    snoop_TLAST,
    input  logic                    snoop_TVALID,
    input  logic                    snoop_TREADY,
    input  logic                    buf_ready,
    output logic [ADDR_WIDTH-1:0]   snooper_wr_addr,
    output logic [63:0]             snooper_wr_data,
    output logic                    snooper_wr_en,
    output logic                    packet_done,
    output logic [ADDR_WIDTH+3:0]   byte_length,
    output logic                    truncated
`ifdef SNOOPER_DROP_COUNT_EN
    ,
    output logic [31:0]             drop_count
`endif
);

    typedef enum logic [1:0] {IDLE, SKIP, CAPTURE} state_t;

    localparam logic [ADDR_WIDTH+3:0] FULL_BYTES = {1'b1, {(ADDR_WIDTH+3){1'b0}}};

    state_t                  state, state_n;
    logic [ADDR_WIDTH:0]     count, count_n;
    logic                    wr_en_n;
    logic [ADDR_WIDTH-1:0]   wr_addr_n;
    logic [63:0]             wr_data_n;
    logic                    done_n;
    logic [ADDR_WIDTH+3:0]   len_n;
    logic                    trunc_n;
    logic                    beat;
    logic                    avail;
    logic [3:0]              keep_bytes;
`ifdef SNOOPER_DROP_COUNT_EN
    logic                    drop_inc;
`endif

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] s;
        s = 4'd0;
        for (int i = 0; i < 8; i++) begin
            s = s + {3'b000, v[i]};
        end
        return s;
    endfunction

    // A registered packet_done marks the guard cycle: packetmem has not yet had time to withdraw buf_ready.
    assign beat       = snoop_TVALID & snoop_TREADY;
    assign avail      = buf_ready & ~packet_done;
    assign keep_bytes = popcount8(snoop_TKEEP);

    // FSM state and word counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
        end
    end

    // Next state, next write strobe and completion info
    always_comb begin
        state_n   = state;
        count_n   = count;
        wr_en_n   = 1'b0;
        wr_addr_n = snooper_wr_addr;
        wr_data_n = snooper_wr_data;
        done_n    = 1'b0;
        len_n     = byte_length;
        trunc_n   = truncated;
`ifdef SNOOPER_DROP_COUNT_EN
        drop_inc  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (beat) begin
                    if (avail) begin
                        wr_en_n   = 1'b1;
                        wr_addr_n = '0;
                        wr_data_n = snoop_TDATA;
                        count_n   = {{ADDR_WIDTH{1'b0}}, 1'b1};
                        if (snoop_TLAST) begin
                            done_n  = 1'b1;
                            len_n   = {{ADDR_WIDTH{1'b0}}, keep_bytes};
                            trunc_n = 1'b0;
                        end else begin
                            state_n = CAPTURE;
                        end
                    end else begin
`ifdef SNOOPER_DROP_COUNT_EN
                        drop_inc = 1'b1;
`endif
                        if (!snoop_TLAST) begin
                            state_n = SKIP;
                        end
                    end
                end
            end
            SKIP: begin
                if (beat && snoop_TLAST) begin
                    state_n = IDLE;
                end
            end
            CAPTURE: begin
                if (beat) begin
                    // Top counter bit set means the buffer is full; further beats are only counted as overflow.
                    if (!count[ADDR_WIDTH]) begin
                        wr_en_n   = 1'b1;
                        wr_addr_n = count[ADDR_WIDTH-1:0];
                        wr_data_n = snoop_TDATA;
                        count_n   = count + {{ADDR_WIDTH{1'b0}}, 1'b1};
                    end
                    if (snoop_TLAST) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                        if (count[ADDR_WIDTH]) begin
                            len_n   = FULL_BYTES;
                            trunc_n = 1'b1;
                        end else begin
                            len_n   = {1'b0, count[ADDR_WIDTH-1:0], 3'b000}
                                    + {{ADDR_WIDTH{1'b0}}, keep_bytes};
                            trunc_n = 1'b0;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Registered write port and completion outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snooper_wr_en   <= 1'b0;
            snooper_wr_addr <= '0;
            snooper_wr_data <= '0;
            packet_done     <= 1'b0;
            byte_length     <= '0;
            truncated       <= 1'b0;
        end else begin
            snooper_wr_en   <= wr_en_n;
            snooper_wr_addr <= wr_addr_n;
            snooper_wr_data <= wr_data_n;
            packet_done     <= done_n;
            byte_length     <= len_n;
            truncated       <= trunc_n;
        end
    end

`ifdef SNOOPER_DROP_COUNT_EN
    // Saturating count of packets dropped for lack of a free buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= '0;
        end else if (drop_inc && (drop_count != 32'hFFFF_FFFF)) begin
            drop_count <= drop_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_packet_snooper.sv
// tb/tb_packet_snooper.sv - randomized self-checking bench for packet_snooper against a packet-level model
module tb_packet_snooper;

    localparam int AW  = 2;
    localparam int CAP = 1 << AW;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [63:0]     snoop_TDATA;
    logic [7:0]      snoop_TKEEP;
    logic            snoop_TLAST;
    logic            snoop_TVALID;
    logic            snoop_TREADY;
    logic            buf_ready;
    logic [AW-1:0]   snooper_wr_addr;
    logic [63:0]     snooper_wr_data;
    logic            snooper_wr_en;
    logic            packet_done;
    logic [AW+3:0]   byte_length;
    logic            truncated;
`ifdef SNOOPER_DROP_COUNT_EN
    logic [31:0]     drop_count;
`endif

    packet_snooper #(.ADDR_WIDTH(AW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .snoop_TDATA     (snoop_TDATA),
        .snoop_TKEEP     (snoop_TKEEP),
        .snoop_TLAST     (snoop_TLAST),
        .snoop_TVALID    (snoop_TVALID),
        .snoop_TREADY    (snoop_TREADY),
        .buf_ready       (buf_ready),
        .snooper_wr_addr (snooper_wr_addr),
        .snooper_wr_data (snooper_wr_data),
        .snooper_wr_en   (snooper_wr_en),
        .packet_done     (packet_done),
        .byte_length     (byte_length),
        .truncated       (truncated)
`ifdef SNOOPER_DROP_COUNT_EN
        ,
        .drop_count      (drop_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packet-level reference: expected writes and completions
    logic [63:0] ewa[$];
    logic [63:0] ewd[$];
    int          elen[$];
    bit          etr[$];
    bit          in_pkt = 0;
    bit          cap_pkt = 0;
    int          nb = 0;
    bit          guard_next = 0;
    int          exp_drops = 0;

    task automatic model_beat(input bit guarded, input logic br, input logic last,
                              input logic [63:0] d, input logic [7:0] k);
        if (!in_pkt) begin
            in_pkt  = 1;
            nb      = 0;
            cap_pkt = br && !guarded;
            if (!cap_pkt) exp_drops++;
        end
        if (cap_pkt && nb < CAP) begin
            ewa.push_back(64'(nb));
            ewd.push_back(d);
        end
        nb++;
        if (last) begin
            in_pkt = 0;
            if (cap_pkt) begin
                elen.push_back(nb > CAP ? 8 * CAP : 8 * (nb - 1) + $countones(k));
                etr.push_back(nb > CAP);
                guard_next = 1;
            end
        end
    endtask

    task automatic model_reset();
        ewa.delete(); ewd.delete(); elen.delete(); etr.delete();
        in_pkt = 0; guard_next = 0;
    endtask

    // One driven cycle: inputs are set after the previous edge and sampled at the next one
    task automatic cycle(input logic v, input logic r, input logic last,
                         input logic [63:0] d, input logic [7:0] k, input logic br);
        bit g;
        snoop_TVALID = v; snoop_TREADY = r; snoop_TLAST = last;
        snoop_TDATA = d; snoop_TKEEP = k; buf_ready = br;
        g = guard_next;
        guard_next = 0;
        if (v && r) model_beat(g, br, last, d, k);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic br);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 64'h0, 8'h0, br);
    endtask

    task automatic drive_pkt(input int n, input logic br0, input logic br1, input logic [7:0] keep_last,
                             input int stall_pct, input int stall_at);
        for (int b = 0; b < n; b++) begin
            logic br;
            int   ni;
            br = (b == 0) ? br0 : br1;
            ni = (stall_pct > 0 && $urandom_range(99) < stall_pct) ? $urandom_range(3, 1) : 0;
            for (int s = 0; s < ni; s++) begin
                logic v;
                v = 1'($urandom_range(1));
                cycle(v, v ? 1'b0 : 1'($urandom_range(1)), 1'($urandom_range(1)),
                      {$urandom, $urandom}, 8'($urandom), br);
            end
            if (b == stall_at) begin
                for (int s = 0; s < 5; s++) cycle(1'b1, 1'b0, 1'b0, {$urandom, $urandom}, 8'hFF, br);
            end
            cycle(1'b1, 1'b1, b == n - 1, {$urandom, $urandom},
                  (b == n - 1) ? keep_last : 8'($urandom), br);
        end
    endtask

    // Output monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (snooper_wr_en) begin
                if (ewa.size() == 0) begin
                    check("wr_unexpected", 64'(snooper_wr_en), 64'h0);
                end else begin
                    check("wr_addr", 64'(snooper_wr_addr), ewa.pop_front());
                    check("wr_data", snooper_wr_data, ewd.pop_front());
                end
            end
            if (packet_done) begin
                if (elen.size() == 0) begin
                    check("done_unexpected", 64'(packet_done), 64'h0);
                end else begin
                    check("byte_length", 64'(byte_length), 64'(elen.pop_front()));
                    check("truncated", 64'(truncated), 64'(etr.pop_front()));
                    check("writes_before_done", 64'(ewa.size()), 64'h0);
                end
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_wr_en"}, 64'(snooper_wr_en), 64'h0);
        check({tag, "_wr_addr"}, 64'(snooper_wr_addr), 64'h0);
        check({tag, "_wr_data"}, snooper_wr_data, 64'h0);
        check({tag, "_done"}, 64'(packet_done), 64'h0);
        check({tag, "_len"}, 64'(byte_length), 64'h0);
        check({tag, "_trunc"}, 64'(truncated), 64'h0);
`ifdef SNOOPER_DROP_COUNT_EN
        check({tag, "_drop_count"}, 64'(drop_count), 64'h0);
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        snoop_TVALID = 0; snoop_TREADY = 0; snoop_TLAST = 0;
        snoop_TDATA = 0; snoop_TKEEP = 0; buf_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;
        idle(2, 1'b0);

        // 3 beats, last keep F0 -> 20 bytes
        drive_pkt(3, 1'b1, 1'b1, 8'hF0, 0, -1);
        idle(3, 1'b0);
        // no buffer at first beat, raised later -> dropped; next packet captured from addr 0
        drive_pkt(4, 1'b0, 1'b1, 8'hFF, 0, -1);
        drive_pkt(2, 1'b1, 1'b1, 8'hC0, 0, -1);
        idle(3, 1'b0);
`ifdef SNOOPER_DROP_COUNT_EN
        check("drop_count_one", 64'(drop_count), 64'(exp_drops));
`endif
        // overflow and exactly-full
        drive_pkt(6, 1'b1, 1'b1, 8'hFF, 0, -1);
        idle(3, 1'b0);
        drive_pkt(4, 1'b1, 1'b1, 8'hFF, 0, -1);
        idle(3, 1'b0);
        // single beat then back-to-back packet in guard cycle, then recovery
        drive_pkt(1, 1'b1, 1'b1, 8'h80, 0, -1);
        drive_pkt(2, 1'b1, 1'b1, 8'hFF, 0, -1);
        drive_pkt(3, 1'b1, 1'b1, 8'h00, 0, -1);
        idle(3, 1'b0);
        // 5-cycle backpressure mid-packet
        drive_pkt(4, 1'b1, 1'b1, 8'hFE, 0, 2);
        idle(3, 1'b0);

        // randomized packets
        for (int p = 0; p < 60; p++) begin
            logic [7:0] kk;
            kk = 8'hFF;
            kk = kk << $urandom_range(8);
            drive_pkt($urandom_range(7, 1), 1'($urandom_range(3) != 0), 1'($urandom_range(1)),
                      kk, 30, ($urandom_range(5) == 0) ? 1 : -1);
            if ($urandom_range(1)) idle($urandom_range(2, 1), 1'($urandom_range(1)));
        end
        idle(3, 1'b0);
`ifdef SNOOPER_DROP_COUNT_EN
        check("drop_count_random", 64'(drop_count), 64'(exp_drops));
`endif
        check("pending_writes", 64'(ewa.size()), 64'h0);
        check("pending_dones", 64'(elen.size()), 64'h0);

        // reset mid-capture: outputs clear at once, no completion
        cycle(1'b1, 1'b1, 1'b0, 64'h1111_2222_3333_4444, 8'hFF, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 64'h5555_6666_7777_8888, 8'hFF, 1'b1);
        idle(1, 1'b1);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        model_reset();
        exp_drops = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2, 1'b0);
        drive_pkt(3, 1'b1, 1'b1, 8'hFF, 0, -1);
        idle(3, 1'b0);
        check("pending_writes_end", 64'(ewa.size()), 64'h0);
        check("pending_dones_end", 64'(elen.size()), 64'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
